// File: rtl/multi_ch_skew_shift_reg.sv
// ---------------------------------------------------------------------------
// multi_ch_skew_shift_reg
//
// Multi-lane, runtime-programmable delay line that feeds operand rows/columns
// into a systolic PE grid. Each lane is an advance-driven shift register. The
// lane output is taken from a programmable tap. With skew enabled, lane c is
// delayed c extra advances, which gives the triangular wavefront.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   cfg_load   : load depth_cfg/skew_en and clear the pipeline
//   depth_cfg  : requested base depth D (clamped into 1..MAX_DEPTH)
//   skew_en    : 1 -> lane c delay = D+c, 0 -> every lane delay = D
//   clear      : synchronous clear of pipeline data and tags, config kept
//   in_valid   : advance all lanes, pushing data_in with tag=1
//   flush      : advance all lanes, pushing zeros with tag=0 (drain)
//   data_in    : lane c sample at [c*DATA_WIDTH +: DATA_WIDTH]
//   data_out   : registered lane outputs, same packing as data_in
//   out_valid  : per-lane one-cycle pulse when a tagged sample is delivered
//   busy       : some tagged sample is still waiting inside lane storage
//   cfg_clamp  : one-cycle pulse when the last cfg_load needed clamping
// ---------------------------------------------------------------------------
module multi_ch_skew_shift_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int MAX_DEPTH  = 27,
    parameter int DEPTH_W    = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_load,
    input  logic [DEPTH_W-1:0]           depth_cfg,
    input  logic                         skew_en,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic                         flush,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]            out_valid,
    output logic                         busy,
    output logic                         cfg_clamp
);

    localparam int STAGES = MAX_DEPTH + NUM_CH - 1;
    // Wide enough for D + (NUM_CH-1) - 1 at maximum settings without wrap.
    localparam int TAP_W  = DEPTH_W + $clog2(NUM_CH) + 1;
    localparam int IDX_W  = $clog2(STAGES);
    localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

    logic [DEPTH_W-1:0] r_depth;
    logic               r_skew;
    logic               r_busy;
    logic               r_cfg_clamp;

    logic               w_wipe;
    logic               w_adv;
    logic               w_push_tag;
    logic [DEPTH_W-1:0] w_depth_clamped;
    logic               w_clamp;
    logic [NUM_CH-1:0]  w_lane_busy_next;

    // cfg_load and clear both drop any concurrent push.
    assign w_wipe     = cfg_load | clear;
    assign w_adv      = ~w_wipe & (in_valid | flush);
    assign w_push_tag = in_valid;

    always_comb begin
        w_depth_clamped = depth_cfg;
        w_clamp         = 1'b0;
        if (depth_cfg == '0) begin
            w_depth_clamped = DEPTH_W'(1);
            w_clamp         = 1'b1;
        end else if (depth_cfg > MAX_D) begin
            w_depth_clamped = MAX_D;
            w_clamp         = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth     <= MAX_D;
            r_skew      <= 1'b0;
            r_cfg_clamp <= 1'b0;
        end else begin
            r_cfg_clamp <= 1'b0;
            if (cfg_load) begin
                r_depth     <= w_depth_clamped;
                r_skew      <= skew_en;
                r_cfg_clamp <= w_clamp;
            end
        end
    end

    // busy is taken from the next-state tags so it tracks storage exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
        end else if (w_wipe) begin
            r_busy <= 1'b0;
        end else if (w_adv) begin
            r_busy <= |w_lane_busy_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] r_data [STAGES];
            logic [STAGES-1:0]     r_tag;
            logic [DATA_WIDTH-1:0] r_out;
            logic                  r_vld;

            logic [TAP_W-1:0]      w_tap;
            logic [IDX_W-1:0]      w_rd_idx;
            logic [DATA_WIDTH-1:0] w_in_data;
            logic [DATA_WIDTH-1:0] w_tap_data;
            logic                  w_tap_tag;
            logic [STAGES-1:0]     w_keep;
            logic [STAGES-1:0]     w_tag_next;

            // Tap 0 is data_in itself; tap t (t>0) is stage t-1.
            assign w_tap     = TAP_W'(r_depth) + (r_skew ? TAP_W'(gi) : '0) - TAP_W'(1);
            assign w_rd_idx  = IDX_W'(w_tap - TAP_W'(1));
            assign w_in_data = in_valid ? data_in[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

            always_comb begin
                w_tap_data = w_in_data;
                w_tap_tag  = w_push_tag;
                if (w_tap != '0) begin
                    w_tap_data = r_data[w_rd_idx];
                    w_tap_tag  = r_tag[w_rd_idx];
                end
            end

            // Stages at or past the tap hold data that has already been
            // delivered; their tags are dropped so busy reflects only
            // samples still waiting for output.
            always_comb begin
                w_keep = '0;
                for (int i = 0; i < STAGES; i++) begin
                    w_keep[i] = (TAP_W'(i) < w_tap);
                end
            end

            assign w_tag_next = {r_tag[STAGES-2:0], w_push_tag} & w_keep;
            assign w_lane_busy_next[gi] = |w_tag_next;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < STAGES; i++) r_data[i] <= '0;
                    r_tag <= '0;
                    r_out <= '0;
                    r_vld <= 1'b0;
                end else if (w_wipe) begin
                    for (int i = 0; i < STAGES; i++) r_data[i] <= '0;
                    r_tag <= '0;
                    r_out <= '0;
                    r_vld <= 1'b0;
                end else if (w_adv) begin
                    r_data[0] <= w_in_data;
                    for (int i = 1; i < STAGES; i++) r_data[i] <= r_data[i-1];
                    r_tag <= w_tag_next;
                    r_out <= w_tap_data;
                    r_vld <= w_tap_tag;
                end else begin
                    r_vld <= 1'b0;
                end
            end

            assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_out;
            assign out_valid[gi] = r_vld;
        end
    endgenerate

    assign busy      = r_busy;
    assign cfg_clamp = r_cfg_clamp;

endmodule

// File: tb/tb_multi_ch_skew_shift_reg.sv
// ---------------------------------------------------------------------------
// Testbench for multi_ch_skew_shift_reg. A reference model records every
// pushed sample by advance number and derives the expected outputs from the
// delay rule (output after advance n = sample pushed at advance n-D_c+1).
// ---------------------------------------------------------------------------
module tb_multi_ch_skew_shift_reg;

    localparam int DW   = 8;
    localparam int NCH  = 4;
    localparam int MAXD = 27;
    localparam int DPW  = 5;
    localparam int HIST = 512;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_load = 1'b0;
    logic [DPW-1:0]   depth_cfg = '0;
    logic             skew_en = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             flush = 1'b0;
    logic [NCH*DW-1:0] data_in = '0;
    logic [NCH*DW-1:0] data_out;
    logic [NCH-1:0]   out_valid;
    logic             busy;
    logic             cfg_clamp;

    multi_ch_skew_shift_reg #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_DEPTH(MAXD), .DEPTH_W(DPW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .depth_cfg(depth_cfg),
        .skew_en(skew_en), .clear(clear), .in_valid(in_valid), .flush(flush),
        .data_in(data_in), .data_out(data_out), .out_valid(out_valid),
        .busy(busy), .cfg_clamp(cfg_clamp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int              m_d;
    int              m_skew;
    int              adv_n;
    logic [DW-1:0]   hist_data [HIST][NCH];
    logic            hist_tag  [HIST];
    logic [NCH*DW-1:0] e_data;
    logic [NCH-1:0]  e_vld;
    logic            e_busy;
    logic            e_clamp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        adv_n  = 0;
        e_data = '0;
        e_vld  = '0;
        e_busy = 1'b0;
    endtask

    task automatic model_step(input logic cl, input logic [DPW-1:0] dc, input logic sk,
                              input logic clr, input logic iv, input logic fl,
                              input logic [NCH*DW-1:0] d);
        e_clamp = 1'b0;
        if (cl) begin
            m_d     = (dc == 0) ? 1 : ((int'(dc) > MAXD) ? MAXD : int'(dc));
            m_skew  = int'(sk);
            e_clamp = (dc == 0) || (int'(dc) > MAXD);
            model_clear();
        end else if (clr) begin
            model_clear();
        end else if (iv || fl) begin
            adv_n++;
            hist_tag[adv_n] = iv;
            for (int c = 0; c < NCH; c++)
                hist_data[adv_n][c] = iv ? d[c*DW +: DW] : '0;
            e_busy = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                int dcl, j;
                dcl = m_d + (m_skew != 0 ? c : 0);
                j   = adv_n - dcl + 1;
                if (j >= 1) begin
                    e_data[c*DW +: DW] = hist_data[j][c];
                    e_vld[c]           = hist_tag[j];
                end else begin
                    e_data[c*DW +: DW] = '0;
                    e_vld[c]           = 1'b0;
                end
                // Tagged samples pushed but not yet delivered on this lane.
                for (int k = (j + 1 < 1 ? 1 : j + 1); k <= adv_n; k++)
                    if (hist_tag[k]) e_busy = 1'b1;
            end
        end else begin
            e_vld = '0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_data"},  32'(data_out),  32'(e_data));
        chk({tag, "_vld"},   32'(out_valid), 32'(e_vld));
        chk({tag, "_busy"},  32'(busy),      32'(e_busy));
        chk({tag, "_clamp"}, 32'(cfg_clamp), 32'(e_clamp));
    endtask

    task automatic step(input string tag, input logic cl, input logic [DPW-1:0] dc,
                        input logic sk, input logic clr, input logic iv, input logic fl,
                        input logic [NCH*DW-1:0] d);
        cfg_load  = cl;
        depth_cfg = dc;
        skew_en   = sk;
        clear     = clr;
        in_valid  = iv;
        flush     = fl;
        data_in   = d;
        @(posedge clk);
        #1;
        model_step(cl, dc, sk, clr, iv, fl, d);
        check_all(tag);
        cfg_load = 1'b0; clear = 1'b0; in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic push(input string tag, input logic [NCH*DW-1:0] d);
        step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic do_flush(input string tag);
        step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic cfg(input string tag, input logic [DPW-1:0] dc, input logic sk);
        step(tag, 1'b1, dc, sk, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [NCH*DW-1:0] d;
        logic [7:0] n8;

        m_d = MAXD; m_skew = 0; e_clamp = 1'b0;
        model_clear();

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        rst_n = 1'b1;

        // Default config D=27, no skew: 0x01..0x1B on all lanes
        for (int n = 1; n <= 27; n++) begin
            n8 = 8'(n);
            push("def", {NCH{n8}});
        end
        chk("def_out27_data", 32'(data_out), 32'h01010101);
        chk("def_out27_vld",  32'(out_valid), 32'hF);
        push("def", {NCH{8'h1C}});
        push("def", {NCH{8'h1D}});

        // Asynchronous reset mid-stream: outputs drop before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data",  32'(data_out),  32'h0);
        chk("arst_vld",   32'(out_valid), 32'h0);
        chk("arst_busy",  32'(busy),      32'h0);
        chk("arst_clamp", 32'(cfg_clamp), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_d = MAXD; m_skew = 0; e_clamp = 1'b0;
        model_clear();
        for (int n = 1; n <= 27; n++) push("post_rst", NCH*DW'($urandom));

        // Skew mode D=2: lane c data = 0x10*c + n
        cfg("skew_cfg", 5'd2, 1'b1);
        for (int n = 1; n <= 8; n++) begin
            for (int c = 0; c < NCH; c++) d[c*DW +: DW] = 8'(16 * c + n);
            push("skew", d);
            if (n == 4) chk("skew_l3_pre", 32'(out_valid[3]), 32'h0);
            if (n == 5) begin
                chk("skew_l3_first_vld",  32'(out_valid[3]),  32'h1);
                chk("skew_l3_first_data", 32'(data_out[31:24]), 32'h31);
            end
        end

        // Gapped input D=3: valid pattern 1,0,0,1,1
        cfg("gap_cfg", 5'd3, 1'b0);
        push("gap", NCH*DW'($urandom));
        idle("gap");
        idle("gap");
        push("gap", NCH*DW'($urandom));
        push("gap", NCH*DW'($urandom));
        repeat (2) idle("gap_hold");
        do_flush("gap_tail");
        do_flush("gap_tail");

        // Flush drain D=4
        cfg("fl_cfg", 5'd4, 1'b0);
        push("fl", NCH*DW'($urandom));
        push("fl", NCH*DW'($urandom));
        for (int i = 0; i < 6; i++) do_flush("fl_drain");

        // Clamp cases and clear collision
        cfg("clamp0", 5'd0, 1'b0);
        chk("clamp0_pulse", 32'(cfg_clamp), 32'h1);
        push("d1", NCH*DW'($urandom));
        push("d1", NCH*DW'($urandom));
        idle("d1");
        cfg("clamp31", 5'd31, 1'b0);
        chk("clamp31_pulse", 32'(cfg_clamp), 32'h1);
        cfg("noclamp", 5'd5, 1'b0);
        push("clr", NCH*DW'($urandom));
        push("clr", NCH*DW'($urandom));
        step("clr_iv", 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, NCH*DW'($urandom));
        chk("clr_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 6; i++) do_flush("clr_after");
        step("iv_fl", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, NCH*DW'($urandom));
        for (int i = 0; i < 6; i++) do_flush("iv_fl_drain");

        // Max depth with skew: lane3 delay 30
        cfg("max_cfg", 5'd27, 1'b1);
        for (int n = 1; n <= 30; n++) begin
            push("max", NCH*DW'($urandom));
            if (n == 29) chk("max_l3_pre", 32'(out_valid[3]), 32'h0);
            if (n == 30) chk("max_l3_first", 32'(out_valid[3]), 32'h1);
        end
        for (int i = 0; i < 4; i++) do_flush("max_drain");

        // Random mix of every operation
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (adv_n > 400 || (r >= 4 && r < 8))
                step("rnd_clr", 1'b0, '0, 1'b0, 1'b1, 1'($urandom), 1'($urandom), NCH*DW'($urandom));
            else if (r < 4)
                step("rnd_cfg", 1'b1, DPW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, NCH*DW'($urandom));
            else if (r < 60)
                step("rnd_iv", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'($urandom), NCH*DW'($urandom));
            else if (r < 80)
                do_flush("rnd_fl");
            else
                idle("rnd_idle");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
